// File: rtl/riscv_defines.sv
// Shared RISC-V widths, multiply opcodes and the multiply-arbiter state type.
package riscv_defines;

  localparam int XLEN         = 32;
  localparam int ALU_OP_WIDTH = 7;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_MUL    = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULH   = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHSU = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_MULHU  = 7'b0110011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } mul_arb_state_t;

endpackage

// File: rtl/asa_riscv_rr_arb2.sv
// Two-way round-robin picker; ptr names the requester granted last.
module asa_riscv_rr_arb2 (
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_nxt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  assign ptr_nxt = advance ? gnt[1] : ptr;

endmodule

// File: rtl/asa_riscv_mul_arb.sv
// Arbitrates two requesters onto one shared multiplier, one operation in flight,
// with flush, timeout abort and per-owner response routing.
module asa_riscv_mul_arb
  import riscv_defines::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    r0_vld,
  output logic                    r0_rdy,
  input  logic [ALU_OP_WIDTH-1:0] r0_op,
  input  logic [XLEN-1:0]         r0_opA,
  input  logic [XLEN-1:0]         r0_opB,
  output logic                    r0_rsp_vld,
  output logic [XLEN-1:0]         r0_rsp_r,
  input  logic                    r1_vld,
  output logic                    r1_rdy,
  input  logic [ALU_OP_WIDTH-1:0] r1_op,
  input  logic [XLEN-1:0]         r1_opA,
  input  logic [XLEN-1:0]         r1_opB,
  output logic                    r1_rsp_vld,
  output logic [XLEN-1:0]         r1_rsp_r,
  input  logic                    flush,
  output logic                    mul_vld,
  output logic [ALU_OP_WIDTH-1:0] mul_op,
  output logic [XLEN-1:0]         mul_opA,
  output logic [XLEN-1:0]         mul_opB,
  input  logic                    mul_busy,
  input  logic                    mul_bubble,
  input  logic [XLEN-1:0]         mul_r,
  output logic                    timeout_err
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  mul_arb_state_t          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ALU_OP_WIDTH-1:0] op_q, op_d;
  logic [XLEN-1:0]         opa_q, opa_d, opb_q, opb_d;
  logic                    owner_q, owner_d;
  logic                    ptr_q, ptr_d;
  logic [1:0]              rsp_vld_q, rsp_vld_d;
  logic [XLEN-1:0]         rsp_r_q, rsp_r_d;
  logic                    err_q, err_d;
  logic [1:0]              req, gnt;
  logic                    hs;

  assign req = (state_q == IDLE && !flush) ? {r1_vld, r0_vld} : 2'b00;
  assign hs  = |gnt;

  asa_riscv_rr_arb2 u_rr (
    .req     (req),
    .advance (hs),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .ptr_nxt (ptr_d)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    owner_d   = owner_q;
    rsp_vld_d = 2'b00;
    rsp_r_d   = rsp_r_q;
    err_d     = err_q;
    mul_vld   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          op_d    = gnt[1] ? r1_op  : r0_op;
          opa_d   = gnt[1] ? r1_opA : r0_opA;
          opb_d   = gnt[1] ? r1_opB : r0_opB;
          owner_d = gnt[1];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (!mul_busy) begin
          mul_vld = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A result arriving together with flush is dropped; the multiplier is already done.
        if (!mul_bubble) begin
          if (!flush) begin
            rsp_vld_d[owner_q] = 1'b1;
            rsp_r_d            = mul_r;
          end
          state_d = IDLE;
        end else if (flush) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else if (cnt_q == CNT_MAX) begin
          err_d              = 1'b1;
          rsp_vld_d[owner_q] = 1'b1;
          rsp_r_d            = '0;
          state_d            = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!mul_bubble) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      owner_q   <= 1'b0;
      ptr_q     <= 1'b1;
      rsp_vld_q <= 2'b00;
      rsp_r_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_r_q   <= rsp_r_d;
      err_q     <= err_d;
    end
  end

  assign r0_rdy      = gnt[0];
  assign r1_rdy      = gnt[1];
  assign r0_rsp_vld  = rsp_vld_q[0];
  assign r1_rsp_vld  = rsp_vld_q[1];
  assign r0_rsp_r    = rsp_vld_q[0] ? rsp_r_q : '0;
  assign r1_rsp_r    = rsp_vld_q[1] ? rsp_r_q : '0;
  assign mul_op      = op_q;
  assign mul_opA     = opa_q;
  assign mul_opB     = opb_q;
  assign timeout_err = err_q;

endmodule
